tour_cmd_seq: RTL and testbench
===============================

Name: tour_cmd_seq

Overview:
- Reader/consumer for the knight's-tour solver. After the solver signals completion, this block walks move indices 0..NUM_MOVES-1 and reads each one-hot move.
- Each move becomes two movement commands for the command processor: a vertical leg first, then a horizontal leg. It uses the same cmd_rdy/clr_cmd_rdy/send_resp handshake as the UART command path.
- When no tour is being replayed, the UART command path passes through the block unchanged.

Parameters:
- NUM_MOVES, 24, number of moves replayed; last index is NUM_MOVES-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_tour  in  1  one-cycle pulse; solver done, begin replay.
- move  in  8  one-hot move from solver at index mv_indx.
- mv_indx  out  5  move index presented to solver.
- cmd_UART  in  16  command from UART wrapper.
- cmd_rdy_UART  in  1  UART command valid.
- clr_cmd_rdy_UART  out  1  consume acknowledge to UART wrapper.
- cmd  out  16  command to command processor.
- cmd_rdy  out  1  cmd valid.
- clr_cmd_rdy  in  1  command processor accepted cmd.
- send_resp  in  1  command processor finished executing cmd.
- resp  out  8  response byte for the UART transmitter.
- err  out  1  sticky flag: a non-one-hot move was read.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Reset forces state=IDLE, mv_indx=0, err=0.
- Combinational outputs after reset (IDLE): cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
- Command format:
  - cmd[15:12]=opcode: 4'b0010 move; 4'b0011 move with fanfare (see option).
  - cmd[11:4]=heading: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
  - cmd[3:0]=square count.
- Move decode (dx,dy), +y=N, +x=E:
  - bit0 (-1,+2); bit1 (+1,+2); bit2 (-2,+1); bit3 (-2,-1)
  - bit4 (-1,-2); bit5 (+1,-2); bit6 (+2,-1); bit7 (+2,+1)
- Vertical leg: heading N if dy>0, else S; count=|dy|.
- Horizontal leg: heading E if dx>0, else W; count=|dx|.
- Illegal move (zero or multiple bits set): both legs issue heading N, count 0; err sets and holds until rst or the next start_tour.
- move is sampled combinationally while mv_indx is stable; mv_indx changes only on a move boundary.
- FSM states and transitions:
  - IDLE: UART passthrough. start_tour -> VERT; mv_indx<=0; err<=0.
  - VERT: cmd=vertical leg, cmd_rdy=1, clr_cmd_rdy_UART=0. clr_cmd_rdy -> HOLD_V.
  - HOLD_V: cmd_rdy=0, cmd held. send_resp -> HORZ.
  - HORZ: cmd=horizontal leg, cmd_rdy=1. clr_cmd_rdy -> HOLD_H.
  - HOLD_H: cmd_rdy=0. On send_resp:
    - if mv_indx==NUM_MOVES-1 -> IDLE, mv_indx<=0;
    - else mv_indx<=mv_indx+1 -> VERT.
- Latency: cmd_rdy rises 1 cycle after start_tour. Next vertical cmd_rdy rises 1 cycle after send_resp in HOLD_H.
- resp:
  - 8'hA5 in IDLE.
  - 8'hA5 during HOLD_H when mv_indx==NUM_MOVES-1 (tour complete).
  - 8'h5A in all other non-IDLE states.
- Boundaries and simultaneous events:
  - start_tour outside IDLE: ignored.
  - cmd_rdy_UART during a tour: held off; clr_cmd_rdy_UART stays 0 and the UART command stays pending.
  - clr_cmd_rdy and send_resp asserted in the same cycle in VERT/HORZ: only clr_cmd_rdy is acted on.
  - send_resp in VERT/HORZ alone: ignored.
  - rst mid-tour: immediate return to IDLE, mv_indx=0.
  - mv_indx never exceeds NUM_MOVES-1.

Optional Feature:
- Macro: TOUR_CMD_FANFARE_EN.
- Defined: horizontal-leg opcode is 4'b0011 (fanfare); vertical-leg opcode stays 4'b0010.
- Undefined: both legs use 4'b0010.

Test Plan:
- Reset with cmd_UART=16'h2013, cmd_rdy_UART=1 -> cmd=16'h2013, cmd_rdy=1, resp=8'hA5, mv_indx=0, err=0.
- start_tour, move=8'h01 -> cycle+1: cmd=16'h2002, cmd_rdy=1. Pulse clr_cmd_rdy, then send_resp -> cmd=16'h23F1 (16'h33F1 with TOUR_CMD_FANFARE_EN), resp=8'h5A.
- move=8'h40 -> vertical 16'h27F1; horizontal 16'h2BF2 (fanfare 16'h3BF2).
- Full 24-move replay with an acknowledging model -> 48 commands, mv_indx steps 0..23. resp=8'hA5 in the final HOLD_H, then IDLE with mv_indx=0.
- move=8'h03 at index 5 -> 16'h2000 issued twice; err=1 and held to end of tour; cleared by the next start_tour.
- rst pulsed during HOLD_V at mv_indx=7 -> IDLE, mv_indx=0, UART passthrough restored. start_tour while in VERT -> no effect on mv_indx.

Source files
------------

// File: rtl/tour_cmd_seq.sv
// Replays a solved knight's tour as vertical/horizontal movement commands, else passes UART commands through.
// Optional build macro TOUR_CMD_FANFARE_EN selects the fanfare opcode for horizontal legs.
module tour_cmd_seq #(
    parameter int NUM_MOVES = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        err
);

    typedef enum logic [2:0] {IDLE, VERT, HOLD_V, HORZ, HOLD_H} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);
    localparam logic [7:0] HEAD_N   = 8'h00;
    localparam logic [7:0] HEAD_W   = 8'h3F;
    localparam logic [7:0] HEAD_S   = 8'h7F;
    localparam logic [7:0] HEAD_E   = 8'hBF;
    localparam logic [3:0] OP_MOVE  = 4'b0010;
`ifdef TOUR_CMD_FANFARE_EN
    localparam logic [3:0] OP_HORZ  = 4'b0011;
`else
    localparam logic [3:0] OP_HORZ  = OP_MOVE;
`endif
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    state_t     state;
    logic       legal;
    logic [7:0] v_head, h_head;
    logic [3:0] v_cnt, h_cnt;

    // Each one-hot move splits into |dy| squares N/S, then |dx| squares E/W.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        legal  = 1'b1;
        v_head = HEAD_N;
        v_cnt  = 4'd0;
        h_head = HEAD_N;
        h_cnt  = 4'd0;
        case (move)
            8'h01:   begin v_head = HEAD_N; v_cnt = 4'd2; h_head = HEAD_W; h_cnt = 4'd1; end
            8'h02:   begin v_head = HEAD_N; v_cnt = 4'd2; h_head = HEAD_E; h_cnt = 4'd1; end
            8'h04:   begin v_head = HEAD_N; v_cnt = 4'd1; h_head = HEAD_W; h_cnt = 4'd2; end
            8'h08:   begin v_head = HEAD_S; v_cnt = 4'd1; h_head = HEAD_W; h_cnt = 4'd2; end
            8'h10:   begin v_head = HEAD_S; v_cnt = 4'd2; h_head = HEAD_W; h_cnt = 4'd1; end
            8'h20:   begin v_head = HEAD_S; v_cnt = 4'd2; h_head = HEAD_E; h_cnt = 4'd1; end
            8'h40:   begin v_head = HEAD_S; v_cnt = 4'd1; h_head = HEAD_E; h_cnt = 4'd2; end
            8'h80:   begin v_head = HEAD_N; v_cnt = 4'd1; h_head = HEAD_E; h_cnt = 4'd2; end
            default: legal = 1'b0;
        endcase
    end

    // Outside a tour the UART path is wired straight through.
    always_comb begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        case (state)
            VERT, HOLD_V: begin
                cmd              = {OP_MOVE, v_head, v_cnt};
                cmd_rdy          = (state == VERT);
                clr_cmd_rdy_UART = 1'b0;
                resp             = RESP_BUSY;
            end
            HORZ, HOLD_H: begin
                cmd              = {OP_HORZ, h_head, h_cnt};
                cmd_rdy          = (state == HORZ);
                clr_cmd_rdy_UART = 1'b0;
                resp             = (state == HOLD_H && mv_indx == LAST_IDX) ? RESP_DONE : RESP_BUSY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
        if (rst) begin
            state   <= IDLE;
            mv_indx <= '0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_tour) begin
                    state   <= VERT;
                    mv_indx <= '0;
                    err     <= 1'b0;
                end
                VERT: begin
                    if (!legal)      err   <= 1'b1;
                    if (clr_cmd_rdy) state <= HOLD_V;
                end
                HOLD_V: if (send_resp) state <= HORZ;
                HORZ: begin
                    if (!legal)      err   <= 1'b1;
                    if (clr_cmd_rdy) state <= HOLD_H;
                end
                HOLD_H: if (send_resp) begin
                    if (mv_indx == LAST_IDX) begin
                        state   <= IDLE;
                        mv_indx <= '0;
                    end else begin
                        state   <= VERT;
                        mv_indx <= mv_indx + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Scoreboard bench for tour_cmd_seq: stimulus queues expected legs, a command-processor model pops and checks them.
module tb_tour_cmd_seq;

    localparam int NUM_MOVES = 24;
`ifdef TOUR_CMD_FANFARE_EN
    localparam bit FANFARE = 1'b1;
`else
    localparam bit FANFARE = 1'b0;
`endif

    typedef struct {
        logic [15:0] cmd;
        int          idx;
        bit          err;
        bit          last;
        bit          vert;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_tour = 1'b0;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART = 16'h2013;
    logic        cmd_rdy_UART = 1'b1;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [7:0]  resp;
    logic        err;

    logic [7:0] moves [NUM_MOVES];
    exp_t       sb [$];
    int         n_vec = 0;
    int         n_miss = 0;
    int         abort_idx = -1;
    bit         abort_req = 1'b0;
    bit         tour_done = 1'b0;
    bit         idle_probe = 1'b0;

    tour_cmd_seq #(.NUM_MOVES(NUM_MOVES)) dut (
        .clk(clk), .rst(rst), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
        .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
        .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .resp(resp), .err(err)
    );

    always #5 clk = ~clk;

    // Solver model: the move table is read at whatever index the DUT presents.
    always_comb move = (int'(mv_indx) < NUM_MOVES) ? moves[int'(mv_indx)] : 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Knight displacement from the bit position, then split into legs.
    function automatic logic [15:0] leg(input logic [7:0] m, input bit vert);
        int dx[8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
        int dy[8] = '{ 2, 2, 1, -1, -2, -2, -1, 1};
        logic [3:0] op = (!vert && FANFARE) ? 4'b0011 : 4'b0010;
        int d = 0;
        logic [7:0] hd = 8'h00;
        if ($countones(m) != 1) return {op, 8'h00, 4'h0};
        for (int b = 0; b < 8; b++) begin
            if (m[b]) begin
                d  = vert ? dy[b] : dx[b];
                hd = vert ? ((d > 0) ? 8'h00 : 8'h7F) : ((d > 0) ? 8'hBF : 8'h3F);
            end
        end
        if (d < 0) d = -d;
        return {op, hd, 4'(d)};
    endfunction

    function automatic logic [7:0] rand_move(input int illegal_pct);
        logic [7:0] m;
        if (int'($urandom_range(0, 99)) < illegal_pct) begin
            m = 8'($urandom_range(0, 255));
            if ($countones(m) == 1) m = m | {m[6:0], m[7]};
            return m;
        end
        m = 8'h01;
        return m << $urandom_range(0, 7);
    endfunction

    task automatic load_tour();
        bit sticky = 1'b0;
        for (int i = 0; i < NUM_MOVES; i++) begin
            if ($countones(moves[i]) != 1) sticky = 1'b1;
            sb.push_back('{leg(moves[i], 1'b1), i, sticky, 1'b0, 1'b1});
            sb.push_back('{leg(moves[i], 1'b0), i, sticky, i == NUM_MOVES - 1, 1'b0});
        end
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_idx"}, 32'(mv_indx), 0);
        chk({nm, "_cmd"}, 32'(cmd), 32'(cmd_UART));
        chk({nm, "_rdy"}, 32'(cmd_rdy), 32'(cmd_rdy_UART));
        chk({nm, "_resp"}, 32'(resp), 32'hA5);
    endtask

    task automatic run_tour(input int abort_at, input bit exp_err_end);
        logic [15:0] first_v = leg(moves[0], 1'b1);
        load_tour();
        abort_idx = abort_at;
        tour_done = 1'b0;
        cmd_rdy_UART = 1'b1;
        cmd_UART = 16'($urandom);
        @(negedge clk) start_tour = 1'b1;
        // Holding start_tour a second cycle lands it in VERT, where it must be ignored.
        @(negedge clk);
        chk("start_latency_rdy", 32'(cmd_rdy), 1);
        chk("start_latency_cmd", 32'(cmd), 32'(first_v));
        @(negedge clk) start_tour = 1'b0;
        repeat ($urandom_range(4, 20)) @(negedge clk);
        start_tour = 1'b1;
        @(negedge clk) start_tour = 1'b0;
        if (abort_at < 0) begin
            for (int k = 0; k < 4000 && !tour_done; k++) @(negedge clk);
            chk("tour_done_timeout", 32'(tour_done), 1);
            @(negedge clk);
            check_idle("tour_end");
            chk("tour_end_err", 32'(err), 32'(exp_err_end));
        end else begin
            for (int k = 0; k < 4000 && !abort_req; k++) @(negedge clk);
            chk("abort_timeout", 32'(abort_req), 1);
            chk("abort_at_idx", 32'(mv_indx), 32'(abort_at));
            #2 rst = 1'b1;
            #1 check_idle("mid_reset");
            chk("mid_reset_err", 32'(err), 0);
            @(negedge clk) rst = 1'b0;
            abort_req = 1'b0;
        end
        sb.delete();
        abort_idx = -1;
    endtask

    // Command-processor model: accepts, checks and acknowledges every tour leg.
    initial begin : monitor
        exp_t e;
        bit   both;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (idle_probe) begin
                clr_cmd_rdy = 1'b1;
                #1 chk("clr_passthru_hi", 32'(clr_cmd_rdy_UART), 1);
                @(negedge clk) clr_cmd_rdy = 1'b0;
                #1 chk("clr_passthru_lo", 32'(clr_cmd_rdy_UART), 0);
                idle_probe = 1'b0;
            end else if (cmd_rdy && resp == 8'h5A) begin
                if (sb.size() == 0) begin
                    chk("unexpected_cmd", 32'(cmd), 32'hFFFF_FFFF);
                    continue;
                end
                e = sb.pop_front();
                chk("cmd", 32'(cmd), 32'(e.cmd));
                chk("cmd_idx", 32'(mv_indx), 32'(e.idx));
                if ($urandom_range(0, 3) == 0) begin
                    send_resp = 1'b1;
                    @(negedge clk) send_resp = 1'b0;
                    chk("lone_send_resp_ignored", 32'(cmd_rdy), 1);
                end
                both = ($urandom_range(0, 3) == 0);
                clr_cmd_rdy = 1'b1;
                send_resp = both;
                #1 chk("uart_held_off", 32'(clr_cmd_rdy_UART), 0);
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                send_resp = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                chk("hold_rdy", 32'(cmd_rdy), 0);
                chk("hold_cmd", 32'(cmd), 32'(e.cmd));
                chk("hold_resp", 32'(resp), e.last ? 32'hA5 : 32'h5A);
                chk("hold_err", 32'(err), 32'(e.err));
                chk("hold_idx", 32'(mv_indx), 32'(e.idx));
                if (e.vert && e.idx == abort_idx) begin
                    abort_req = 1'b1;
                    for (int k = 0; k < 1000 && abort_req; k++) @(negedge clk);
                    continue;
                end
                send_resp = 1'b1;
                @(negedge clk) send_resp = 1'b0;
                if (e.last) begin
                    chk("final_resp", 32'(resp), 32'hA5);
                    chk("final_idx", 32'(mv_indx), 0);
                    tour_done = 1'b1;
                end else begin
                    chk("next_leg_latency", 32'(cmd_rdy), 1);
                end
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < NUM_MOVES; i++) moves[i] = 8'h01;
        #1 check_idle("in_reset");
        chk("in_reset_err", 32'(err), 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("reset_cmd", 32'(cmd), 32'h2013);
        chk("reset_rdy", 32'(cmd_rdy), 1);
        chk("reset_resp", 32'(resp), 32'hA5);
        chk("reset_idx", 32'(mv_indx), 0);
        chk("reset_err", 32'(err), 0);

        for (int t = 0; t < 4; t++) begin
            cmd_UART = 16'($urandom);
            cmd_rdy_UART = 1'($urandom);
            @(negedge clk) check_idle("idle_passthru");
        end
        idle_probe = 1'b1;
        for (int k = 0; k < 20 && idle_probe; k++) @(negedge clk);
        chk("idle_probe_done", 32'(idle_probe), 0);

        // Directed tour: known legs at 0 and 1, illegal move at index 5.
        for (int i = 0; i < NUM_MOVES; i++) moves[i] = rand_move(0);
        moves[0] = 8'h01;
        moves[1] = 8'h40;
        moves[5] = 8'h03;
        chk("model_0x01_vert", 32'(leg(moves[0], 1'b1)), 32'h2002);
        chk("model_0x40_vert", 32'(leg(moves[1], 1'b1)), 32'h27F1);
        run_tour(-1, 1'b1);
        chk("uart_still_pending", 32'(cmd_rdy), 1);

        // All-legal tour shows err cleared by the new start_tour.
        for (int i = 0; i < NUM_MOVES; i++) moves[i] = rand_move(0);
        run_tour(-1, 1'b0);

        for (int t = 0; t < 2; t++) begin
            bit any_bad = 1'b0;
            for (int i = 0; i < NUM_MOVES; i++) begin
                moves[i] = rand_move(10);
                if ($countones(moves[i]) != 1) any_bad = 1'b1;
            end
            run_tour(-1, any_bad);
        end

        for (int i = 0; i < NUM_MOVES; i++) moves[i] = rand_move(0);
        run_tour(7, 1'b0);
        cmd_rdy_UART = 1'b0;
        repeat (3) @(negedge clk) check_idle("after_abort");

        for (int i = 0; i < NUM_MOVES; i++) moves[i] = rand_move(0);
        run_tour(-1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
